// File: rtl/bpsk_frame_modulator_if.sv
// Byte handshake between a data source and the BPSK frame modulator.
interface bpsk_frame_modulator_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/bpsk_frame_modulator.sv
// Buffers bytes in a small FIFO and emits them as start/8 data/stop NRZ symbols,
// paced by toggles of a selected phase-accumulator bit.
module bpsk_frame_modulator #(
  parameter logic signed [15:0] AMPLITUDE  = 16'sd16384,
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              phase,
  input  logic [4:0]               sample_rate,
  input  logic                     enable,
  bpsk_frame_modulator_if.slave    src,
  output logic signed [15:0]       signal_out,
  output logic                     busy,
  output logic                     underrun
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic              prev_bit;
  logic              tick;
  logic [7:0]        shift, shift_next;
  logic [3:0]        bit_cnt, bit_cnt_next;
  logic signed [15:0] sig_next;
  logic              underrun_next;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              ready_q;
  logic              push, pop;
  logic              fifo_empty;
  logic              can_start;

  function automatic logic signed [15:0] level(input logic b);
    return b ? AMPLITUDE : -AMPLITUDE;
  endfunction

  assign tick       = phase[sample_rate] ^ prev_bit;
  assign fifo_empty = (count == CNT_W'(0));
  assign can_start  = enable && !fifo_empty;
  assign push       = src.data_valid && ready_q;
  assign src.data_ready = ready_q;
  assign busy       = (state != IDLE);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= src.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        IDLE:    if (can_start) state_next = START;
        START:   state_next = DATA;
        DATA:    if (bit_cnt == 4'd8) state_next = STOP;
        STOP:    state_next = can_start ? START : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pop           = 1'b0;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    sig_next      = signal_out;
    underrun_next = 1'b0;
    if (tick) begin
      case (state)
        IDLE, STOP: begin
          if (can_start) begin
            pop          = 1'b1;
            shift_next   = mem[rd_ptr];
            bit_cnt_next = '0;
            sig_next     = -AMPLITUDE;
          end else begin
            sig_next      = '0;
            underrun_next = (state == STOP) && enable;
          end
        end
        START: begin
          sig_next     = level(shift[0]);
          bit_cnt_next = 4'd1;
        end
        DATA: begin
          if (bit_cnt < 4'd8) begin
            shift_next   = {1'b0, shift[7:1]};
            sig_next     = level(shift[1]);
            bit_cnt_next = bit_cnt + 4'd1;
          end else begin
            sig_next = AMPLITUDE;
          end
        end
        default: sig_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bit   <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      signal_out <= '0;
      underrun   <= 1'b0;
    end else begin
      prev_bit   <= phase[sample_rate];
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      signal_out <= sig_next;
      underrun   <= underrun_next;
    end
  end

endmodule
